// File: rtl/sel_sequencer.sv
// sel_sequencer
//   Walks a 5:1 mux select through codes 0..4 and holds each code for DWELL
//   cycles. The mux output is captured on the last dwell cycle of each code,
//   and the five bits are published together as frame_out when the frame
//   completes.
//
//   Parameter
//     DWELL      cycles each select code is held (1..15)
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     start      request one frame (honoured only in IDLE)
//     hold       freeze the scan while high (SCAN only)
//     y_in       downstream mux output, sampled as frame data
//     sel[2:0]   mux select; parked at 3'b101 outside SCAN
//     busy       high in SCAN and DONE
//     done       one-cycle pulse when frame_out is loaded
//     frame_out  last completed frame; bit k captured while sel==k
//     parity     XOR of frame_out when SEL_SEQUENCER_PARITY_EN is defined,
//                otherwise tied to 0
//
//   Optional feature macro: SEL_SEQUENCER_PARITY_EN
module sel_sequencer #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  input  logic       y_in,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [4:0] frame_out,
  output logic       parity
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Code 5 is not wired to any mux input, so the mux drives 0 while parked.
  localparam logic [2:0] SEL_PARK = 3'b101;
  localparam logic [2:0] SEL_LAST = 3'd4;
  localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

  logic [1:0] r_state;
  logic [2:0] r_sel;
  logic [3:0] r_cnt;
  logic [4:0] r_cap;
  logic [4:0] r_frame;

  logic       w_step;
  logic       w_last;
  logic [4:0] w_cap_nxt;

  assign w_step = (r_state == S_SCAN) && !hold;
  assign w_last = w_step && (r_cnt == CNT_LAST);

  // Capture vector including this cycle's sample, so the final bit can be
  // published into frame_out on the same edge it is captured.
  always_comb begin
    w_cap_nxt = r_cap;
    for (int k = 0; k < 5; k++) begin
      if (w_last && (r_sel == 3'(k))) w_cap_nxt[k] = y_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= SEL_PARK;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_frame <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SCAN;
            r_sel   <= '0;
            r_cnt   <= '0;
          end
        end
        S_SCAN: begin
          if (w_step) begin
            if (w_last) begin
              r_cnt <= '0;
              r_cap <= w_cap_nxt;
              if (r_sel == SEL_LAST) begin
                r_state <= S_DONE;
                r_sel   <= SEL_PARK;
                r_frame <= w_cap_nxt;
              end else begin
                r_sel <= r_sel + 3'd1;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here; a new frame always
          // passes through one IDLE cycle.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= SEL_PARK;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign busy      = (r_state == S_SCAN) || (r_state == S_DONE);
  assign done      = (r_state == S_DONE);
  assign frame_out = r_frame;

`ifdef SEL_SEQUENCER_PARITY_EN
  logic r_parity;

  // Loaded on the same edge as frame_out so the two never disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_last && (r_sel == SEL_LAST)) begin
      r_parity <= ^w_cap_nxt;
    end
  end

  assign parity = r_parity;
`else
  assign parity = 1'b0;
`endif

endmodule
